// File: rtl/ctrl_sequencer_pkg.sv
// Shared definitions for the multi-cycle control sequencer.
// The package is named cpu_pkg. The HALT state exists only when SEQ_ILLEGAL_TRAP_EN is defined.
package cpu_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_BRANCH = 7'h63;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_WRITEBACK = 3'd3
`ifdef SEQ_ILLEGAL_TRAP_EN
    , ST_HALT    = 3'd4
`endif
  } seq_state_e;

  typedef struct packed {
    logic       reg_write;
    logic [2:0] alu_ctrl;
    logic       alu_src;
    logic       imm_src;
    logic       branch;
  } ctrl_bundle_t;

endpackage

// File: rtl/ctrl_sequencer_if.sv
// Instruction-memory fetch handshake between the sequencer (master) and memory (slave).
interface ctrl_sequencer_if;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] instr;

  modport master (output imem_req, input imem_ack, input instr);
  modport slave  (input imem_req, output imem_ack, output instr);
endinterface

// File: rtl/ctrl_sequencer_decode.sv
// Combinational opcode decoder: opcode in, control bundle and illegal flag out.
module seq_decode
  import cpu_pkg::*;
(
  input  logic [6:0]   i_opcode,
  output ctrl_bundle_t o_ctrl,
  output logic         o_illegal
);

  always_comb begin
    o_ctrl    = '0;
    o_illegal = 1'b0;
    case (i_opcode)
      OPC_OP_IMM: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_ctrl  = ALU_ADD;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.imm_src   = 1'b1;
      end
      OPC_BRANCH: begin
        o_ctrl.alu_ctrl  = ALU_SUB;
        o_ctrl.branch    = 1'b1;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer driving datapath strobes.
// Optional feature macro SEQ_ILLEGAL_TRAP_EN: unsupported opcodes halt and set a sticky illegal flag.
module ctrl_sequencer
  import cpu_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ctrl_sequencer_if.master     imem,
  input  logic                 eq,
  output logic                 ir_we,
  output logic                 reg_write,
  output logic [2:0]           alu_ctrl,
  output logic                 alu_src,
  output logic                 imm_src,
  output logic                 pc_we,
  output logic                 pc_src,
  output logic [INSTRET_W-1:0] instret
`ifdef SEQ_ILLEGAL_TRAP_EN
  , output logic               illegal
`endif
);

  seq_state_e            r_state;
  seq_state_e            w_state_nxt;
  logic                  r_run;
  logic [6:0]            r_opc;
  ctrl_bundle_t          r_ctrl;
  ctrl_bundle_t          w_dec_ctrl;
  logic                  w_illegal;
  logic [INSTRET_W-1:0]  r_instret;
  logic                  w_imem_req;
  logic                  w_ir_we;
  logic                  w_reg_write;
  logic [2:0]            w_alu_ctrl;
  logic                  w_alu_src;
  logic                  w_imm_src;
  logic                  w_pc_we;
  logic                  w_pc_src;
  logic                  w_unused;

  seq_decode u_decode (
    .i_opcode  (r_opc),
    .o_ctrl    (w_dec_ctrl),
    .o_illegal (w_illegal)
  );

  // r_run keeps imem_req low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_FETCH;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_imem_req  = 1'b0;
    w_ir_we     = 1'b0;
    w_reg_write = 1'b0;
    w_alu_ctrl  = 3'b000;
    w_alu_src   = 1'b0;
    w_imm_src   = 1'b0;
    w_pc_we     = 1'b0;
    w_pc_src    = 1'b0;
    case (r_state)
      ST_FETCH: begin
        if (r_run) begin
          w_imem_req = 1'b1;
          if (imem.imem_ack) begin
            w_ir_we     = 1'b1;
            w_state_nxt = ST_DECODE;
          end
        end
      end
      ST_DECODE: begin
        w_state_nxt = ST_EXECUTE;
`ifdef SEQ_ILLEGAL_TRAP_EN
        if (w_illegal) w_state_nxt = ST_HALT;
`endif
      end
      ST_EXECUTE: begin
        w_alu_ctrl  = r_ctrl.alu_ctrl;
        w_alu_src   = r_ctrl.alu_src;
        w_imm_src   = r_ctrl.imm_src;
        w_state_nxt = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        w_alu_ctrl  = r_ctrl.alu_ctrl;
        w_alu_src   = r_ctrl.alu_src;
        w_imm_src   = r_ctrl.imm_src;
        w_pc_we     = 1'b1;
        w_reg_write = r_ctrl.reg_write;
        w_pc_src    = r_ctrl.branch & eq;
        w_state_nxt = ST_FETCH;
      end
`ifdef SEQ_ILLEGAL_TRAP_EN
      ST_HALT: w_state_nxt = ST_HALT;
`endif
      default: w_state_nxt = ST_FETCH;
    endcase
  end

  // Opcode is data: captured only on the accepted fetch, no reset needed.
  always_ff @(posedge clk) begin
    if (w_ir_we) r_opc <= imem.instr[6:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl    <= '0;
      r_instret <= '0;
    end else begin
      if (r_state == ST_DECODE) r_ctrl <= w_dec_ctrl;
      if (w_pc_we) r_instret <= r_instret + 1'b1;
    end
  end

`ifdef SEQ_ILLEGAL_TRAP_EN
  logic r_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                r_illegal <= 1'b0;
    else if (r_state == ST_DECODE && w_illegal) r_illegal <= 1'b1;
  end

  assign illegal  = r_illegal;
  assign w_unused = ^imem.instr[31:7];
`else
  assign w_unused = ^{imem.instr[31:7], w_illegal};
`endif

  assign imem.imem_req = w_imem_req;
  assign ir_we         = w_ir_we;
  assign reg_write     = w_reg_write;
  assign alu_ctrl      = w_alu_ctrl;
  assign alu_src       = w_alu_src;
  assign imm_src       = w_imm_src;
  assign pc_we         = w_pc_we;
  assign pc_src        = w_pc_src;
  assign instret       = r_instret;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed self-checking bench for ctrl_sequencer (instret width 4 to exercise wrap).
module tb_ctrl_sequencer;

  localparam int INSTRET_W = 4;
  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_BNE  = 32'hFE209EE3;
  localparam logic [31:0] I_BAD  = 32'h00000033;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 eq = 1'b0;
  logic                 ir_we, reg_write, alu_src, imm_src, pc_we, pc_src;
  logic [2:0]           alu_ctrl;
  logic [INSTRET_W-1:0] instret;
`ifdef SEQ_ILLEGAL_TRAP_EN
  logic                 illegal;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int exp_ret = 0;

  ctrl_sequencer_if u_if ();

  ctrl_sequencer #(.INSTRET_W(INSTRET_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .imem      (u_if),
    .eq        (eq),
    .ir_we     (ir_we),
    .reg_write (reg_write),
    .alu_ctrl  (alu_ctrl),
    .alu_src   (alu_src),
    .imm_src   (imm_src),
    .pc_we     (pc_we),
    .pc_src    (pc_src),
    .instret   (instret)
`ifdef SEQ_ILLEGAL_TRAP_EN
    , .illegal (illegal)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_req"},     32'(u_if.imem_req), 32'd0);
    chk({tag, "_irwe"},    32'(ir_we),         32'd0);
    chk({tag, "_rw"},      32'(reg_write),     32'd0);
    chk({tag, "_alu"},     32'(alu_ctrl),      32'd0);
    chk({tag, "_asrc"},    32'(alu_src),       32'd0);
    chk({tag, "_isrc"},    32'(imm_src),       32'd0);
    chk({tag, "_pcwe"},    32'(pc_we),         32'd0);
    chk({tag, "_pcsrc"},   32'(pc_src),        32'd0);
    chk({tag, "_instret"}, 32'(instret),       32'd0);
`ifdef SEQ_ILLEGAL_TRAP_EN
    chk({tag, "_illegal"}, 32'(illegal),       32'd0);
`endif
  endtask

  // Entered during a FETCH cycle, shortly after a falling edge; returns in the next FETCH cycle.
  task automatic run_instr(input logic [31:0] ins, input int dly, input logic eqv,
                           input logic e_rw, input logic [2:0] e_alu, input logic e_src,
                           input logic e_imm, input logic e_pcsrc);
    int cyc;
    cyc = 0;
    for (int d = 0; d < dly; d++) begin
      u_if.imem_ack = 1'b0;
      #1; cyc++;
      chk("wait_req",  32'(u_if.imem_req), 32'd1);
      chk("wait_irwe", 32'(ir_we),         32'd0);
      @(negedge clk);
    end
    u_if.imem_ack = 1'b1;
    u_if.instr    = ins;
    #1; cyc++;
    chk("fetch_req",  32'(u_if.imem_req), 32'd1);
    chk("fetch_irwe", 32'(ir_we),         32'd1);
    chk("fetch_asrc", 32'(alu_src),       32'd0);
    chk("fetch_pcwe", 32'(pc_we),         32'd0);
    @(negedge clk);
    u_if.instr = 32'hFFFF_FFFF;
    eq = ~eqv;
    #1; cyc++;
    chk("dec_req",  32'(u_if.imem_req), 32'd0);
    chk("dec_irwe", 32'(ir_we),         32'd0);
    chk("dec_alu",  32'(alu_ctrl),      32'd0);
    chk("dec_asrc", 32'(alu_src),       32'd0);
    @(negedge clk);
    u_if.imem_ack = 1'b0;
    #1; cyc++;
    chk("ex_alu",   32'(alu_ctrl),  32'(e_alu));
    chk("ex_asrc",  32'(alu_src),   32'(e_src));
    chk("ex_isrc",  32'(imm_src),   32'(e_imm));
    chk("ex_pcwe",  32'(pc_we),     32'd0);
    chk("ex_rw",    32'(reg_write), 32'd0);
    chk("ex_pcsrc", 32'(pc_src),    32'd0);
    @(negedge clk);
    eq = eqv;
    #1; cyc++;
    chk("wb_pcwe",    32'(pc_we),     32'd1);
    chk("wb_rw",      32'(reg_write), 32'(e_rw));
    chk("wb_pcsrc",   32'(pc_src),    32'(e_pcsrc));
    chk("wb_alu",     32'(alu_ctrl),  32'(e_alu));
    chk("wb_asrc",    32'(alu_src),   32'(e_src));
    chk("wb_isrc",    32'(imm_src),   32'(e_imm));
    chk("wb_instret", 32'(instret),   32'(exp_ret));
    chk("wb_cycle",   32'(cyc),       32'(dly + 4));
    exp_ret = (exp_ret + 1) % 16;
    @(negedge clk);
    eq = 1'b0;
    #1;
    chk("nxt_instret", 32'(instret),       32'(exp_ret));
    chk("nxt_req",     32'(u_if.imem_req), 32'd1);
    chk("nxt_pcwe",    32'(pc_we),         32'd0);
    chk("nxt_rw",      32'(reg_write),     32'd0);
    chk("nxt_asrc",    32'(alu_src),       32'd0);
  endtask

  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk_idle(tag);
    exp_ret = 0;
    @(negedge clk);
    #1;
    chk_idle({tag, "_hold"});
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk({tag, "_req_after"}, 32'(u_if.imem_req), 32'd1);
  endtask

  initial begin
    u_if.imem_ack = 1'b0;
    u_if.instr    = 32'h0;
    @(negedge clk);
    #1;
    chk_idle("rst");
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rel_req", 32'(u_if.imem_req), 32'd1);

    run_instr(I_ADDI, 0, 1'b0, 1'b1, 3'b000, 1'b1, 1'b1, 1'b0);
    run_instr(I_BNE,  0, 1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 1'b1);
    run_instr(I_BNE,  0, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0);
    run_instr(I_ADDI, 3, 1'b1, 1'b1, 3'b000, 1'b1, 1'b1, 1'b0);

`ifdef SEQ_ILLEGAL_TRAP_EN
    u_if.imem_ack = 1'b1;
    u_if.instr    = I_BAD;
    #1;
    chk("bad_irwe", 32'(ir_we), 32'd1);
    @(negedge clk);
    u_if.imem_ack = 1'b0;
    #1;
    chk("bad_dec_illegal", 32'(illegal), 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      u_if.imem_ack = 1'b1;
      #1;
      chk("halt_illegal", 32'(illegal),       32'd1);
      chk("halt_req",     32'(u_if.imem_req), 32'd0);
      chk("halt_irwe",    32'(ir_we),         32'd0);
      chk("halt_pcwe",    32'(pc_we),         32'd0);
      chk("halt_instret", 32'(instret),       32'(exp_ret));
    end
    u_if.imem_ack = 1'b0;
    pulse_reset("halt_rst");
`else
    run_instr(I_BAD, 1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
`endif

    // Abandon an addi in EXECUTE with an asynchronous reset.
    run_instr(I_ADDI, 0, 1'b0, 1'b1, 3'b000, 1'b1, 1'b1, 1'b0);
    u_if.imem_ack = 1'b1;
    u_if.instr    = I_ADDI;
    @(negedge clk);
    u_if.imem_ack = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_ex_asrc", 32'(alu_src), 32'd1);
    pulse_reset("mid_rst");

    for (int k = 0; k < 16; k++)
      run_instr(I_ADDI, 0, 1'b0, 1'b1, 3'b000, 1'b1, 1'b1, 1'b0);
    chk("wrap_instret", 32'(instret), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
